// File: rtl/stage_if.sv
// stage_if: instruction fetch stage, byte-serial fetch with a one-entry skid buffer.
// Define ICACHE_EN to add a direct-mapped one-word-per-line instruction cache.
module stage_if #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          ICACHE_LINES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    localparam logic [2:0] FETCH0 = 3'd0;
    localparam logic [2:0] FETCH1 = 3'd1;
    localparam logic [2:0] FETCH2 = 3'd2;
    localparam logic [2:0] FETCH3 = 3'd3;
    localparam logic [2:0] FULL   = 3'd4;

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of 2 and at least 2");
    end

    logic [2:0]  state;
    logic [1:0]  k;
    logic [31:0] fpc;
    logic [23:0] wbuf;
    logic [31:0] skid_pc;
    logic [31:0] skid_inst;
    logic        hit;
    logic [31:0] hit_word;
    logic        word_done;
    logic [31:0] new_word;

    assign k         = state[1:0];
    assign word_done = hit || ((state == FETCH3) && mem_ack);
    assign new_word  = hit ? hit_word : {mem_rdata, wbuf};
    assign mem_req   = !state[2] && !hit && !reset;
    assign mem_addr  = fpc + {30'b0, k};

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] c_valid;
    logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
    logic [31:0]             c_data [ICACHE_LINES];
    logic [IDX_W-1:0]        c_idx;
    logic [TAG_W-1:0]        c_tagv;
    logic                    fill;

    assign c_idx    = fpc[IDX_W+1:2];
    assign c_tagv   = fpc[31:IDX_W+2];
    assign hit      = (state == FETCH0) && c_valid[c_idx] && (c_tag[c_idx] == c_tagv);
    assign hit_word = c_data[c_idx];
    assign fill     = !reset && !br_taken && (state == FETCH3) && mem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_valid <= '0;
        end else if (fill) begin
            c_valid[c_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            c_tag[c_idx]  <= c_tagv;
            c_data[c_idx] <= new_word;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH0;
            fpc       <= RESET_PC;
            wbuf      <= '0;
            skid_pc   <= '0;
            skid_inst <= '0;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_inst   <= '0;
        end else if (br_taken) begin
            // Redirect flushes the output slot and any buffered word.
            state    <= FETCH0;
            fpc      <= br_target & ~32'h3;
            if_valid <= 1'b0;
        end else if (state == FULL) begin
            if (!stall) begin
                if_pc    <= skid_pc;
                if_inst  <= skid_inst;
                if_valid <= 1'b1;
                state    <= FETCH0;
            end
        end else if (word_done) begin
            fpc <= fpc + 32'd4;
            if (!if_valid || !stall) begin
                if_pc    <= fpc;
                if_inst  <= new_word;
                if_valid <= 1'b1;
                state    <= FETCH0;
            end else begin
                skid_pc   <= fpc;
                skid_inst <= new_word;
                state     <= FULL;
            end
        end else begin
            if (mem_ack) begin
                unique case (state)
                    FETCH0:  wbuf[7:0]   <= mem_rdata;
                    FETCH1:  wbuf[15:8]  <= mem_rdata;
                    default: wbuf[23:16] <= mem_rdata;
                endcase
                state <= state + 3'd1;
            end
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: vector table, directed corner sequences and a random run
// checked by an instruction-stream scoreboard for stage_if.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    stage_if dut (
        .clk(clk), .reset(reset), .stall(stall),
        .br_taken(br_taken), .br_target(br_target),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int ack_wait = 0;
    int waited = 0;
    bit rand_ack = 0;
    int n_consumed = 0;
    logic [31:0] exp_pc = 32'h0;
    bit prev_req = 0;
    bit prev_ack = 0;
    bit prev_flush = 1;
    logic [31:0] prev_addr = 32'h0;

    // Program memory: the word at 0 is the addi from the first bring-up test.
    function automatic logic [7:0] mbyte(input logic [31:0] a);
        logic [31:0] w;
        w = 32'h00100513;
        if (a < 32'd4) return w[8*a[1:0] +: 8];
        return a[7:0] ^ a[15:8] ^ 8'hA5 ^ {a[3:0], a[7:4]};
    endfunction

    function automatic logic [31:0] word(input logic [31:0] a);
        return {mbyte(a + 3), mbyte(a + 2), mbyte(a + 1), mbyte(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic settle();
        #1;
        mem_ack = 1'b0;
        if (mem_req === 1'b1) begin
            if (rand_ack ? ($urandom_range(0, 2) == 0) : (waited >= ack_wait)) begin
                mem_ack = 1'b1;
                mem_rdata = mbyte(mem_addr);
                waited = 0;
            end else begin
                waited++;
            end
        end
        #1;
    endtask

    task automatic tick();
        if (reset) begin
            exp_pc = 32'h0;
        end else if (br_taken) begin
            exp_pc = br_target & ~32'h3;
        end else if (if_valid === 1'b1 && !stall) begin
            check("consume_pc", if_pc, exp_pc);
            check("consume_inst", if_inst, word(exp_pc));
            exp_pc += 32'd4;
            n_consumed++;
        end
        if (prev_req && !prev_ack && !prev_flush && !reset) begin
            check("req_hold", {31'b0, mem_req}, 32'd1);
            check("addr_hold", mem_addr, prev_addr);
        end
        prev_req = (mem_req === 1'b1);
        prev_ack = mem_ack;
        prev_addr = mem_addr;
        prev_flush = reset || br_taken;
        if (reset || br_taken) waited = 0;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        stall = 1'b0;
        br_taken = 1'b0;
        repeat (n) begin
            settle();
            tick();
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic r, input logic [31:0] a,
                                input logic v, input logic [31:0] p);
        vec_t x;
        x.stall = s; x.br = b; x.tgt = t;
        x.req = r; x.addr = a; x.valid = v; x.pc = p;
        return x;
    endfunction

    vec_t tbl[16];

    initial begin
        // Ack every cycle; word 0 then word 4, then a redirect during byte 2.
        tbl[0]  = mk(0, 0, 0,          1, 32'h0,    0, 0);
        tbl[1]  = mk(0, 0, 0,          1, 32'h1,    0, 0);
        tbl[2]  = mk(0, 0, 0,          1, 32'h2,    0, 0);
        tbl[3]  = mk(0, 0, 0,          1, 32'h3,    0, 0);
        tbl[4]  = mk(0, 0, 0,          1, 32'h4,    1, 32'h0);
        tbl[5]  = mk(0, 0, 0,          1, 32'h5,    0, 0);
        tbl[6]  = mk(0, 0, 0,          1, 32'h6,    0, 0);
        tbl[7]  = mk(0, 0, 0,          1, 32'h7,    0, 0);
        tbl[8]  = mk(0, 0, 0,          1, 32'h8,    1, 32'h4);
        tbl[9]  = mk(0, 0, 0,          1, 32'h9,    0, 0);
        tbl[10] = mk(0, 1, 32'h1003,   1, 32'ha,    0, 0);
        tbl[11] = mk(0, 0, 0,          1, 32'h1000, 0, 0);
        tbl[12] = mk(0, 0, 0,          1, 32'h1001, 0, 0);
        tbl[13] = mk(0, 0, 0,          1, 32'h1002, 0, 0);
        tbl[14] = mk(0, 0, 0,          1, 32'h1003, 0, 0);
        tbl[15] = mk(0, 0, 0,          1, 32'h1004, 1, 32'h1000);

        @(negedge clk);
        do_reset(2);

        for (int i = 0; i < 16; i++) begin
            stall = tbl[i].stall;
            br_taken = tbl[i].br;
            br_target = tbl[i].tgt;
            settle();
            check($sformatf("tbl%0d_req", i), {31'b0, mem_req}, {31'b0, tbl[i].req});
            check($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].valid});
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_pc", i), if_pc, tbl[i].pc);
                check($sformatf("tbl%0d_inst", i), if_inst, word(tbl[i].pc));
            end
            tick();
        end
        br_taken = 1'b0;

        // Reset while byte 1 of the word at 0x1004 is outstanding.
        reset = 1'b1;
        settle();
        check("rst_req_low", {31'b0, mem_req}, 32'd0);
        tick();
        reset = 1'b0;
        settle();
        check("rst_valid", {31'b0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_req", {31'b0, mem_req}, 32'd1);
        check("rst_addr", mem_addr, 32'h0);
        tick();
        repeat (3) begin
            settle();
            tick();
        end
        settle();
        check("rst_word_valid", {31'b0, if_valid}, 32'd1);
        check("rst_word_pc", if_pc, 32'h0);
        check("rst_word_inst", if_inst, 32'h00100513);
        tick();

        // Stall for 12 cycles while the first word is presented.
        do_reset(2);
        repeat (4) begin
            settle();
            tick();
        end
        stall = 1'b1;
        for (int i = 0; i < 12; i++) begin
            settle();
            check("stall_valid", {31'b0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h0);
            check("stall_inst", if_inst, 32'h00100513);
            if (i >= 4) check("stall_req_low", {31'b0, mem_req}, 32'd0);
            tick();
        end
        stall = 1'b0;
        settle();
        check("unstall_pc0", if_pc, 32'h0);
        tick();
        settle();
        check("skid_valid", {31'b0, if_valid}, 32'd1);
        check("skid_pc", if_pc, 32'h4);
        check("skid_inst", if_inst, word(32'h4));
        check("skid_req", {31'b0, mem_req}, 32'd1);
        check("skid_addr", mem_addr, 32'h8);
        tick();

        // Each byte acked after three wait cycles.
        do_reset(2);
        ack_wait = 3;
        for (int c = 0; c < 16; c++) begin
            settle();
            check("slow_valid", {31'b0, if_valid}, 32'd0);
            check("slow_req", {31'b0, mem_req}, 32'd1);
            check("slow_addr", mem_addr, 32'(c / 4));
            tick();
        end
        settle();
        check("slow_done_valid", {31'b0, if_valid}, 32'd1);
        check("slow_done_inst", if_inst, 32'h00100513);
        tick();
        ack_wait = 0;

`ifdef ICACHE_EN
        // Word 0 is cached on its first pass; jumping back must hit.
        do_reset(2);
        repeat (5) begin
            settle();
            tick();
        end
        br_taken = 1'b1;
        br_target = 32'h0;
        settle();
        tick();
        br_taken = 1'b0;
        settle();
        check("hit_no_req", {31'b0, mem_req}, 32'd0);
        tick();
        settle();
        check("hit_valid", {31'b0, if_valid}, 32'd1);
        check("hit_pc", if_pc, 32'h0);
        check("hit_inst", if_inst, 32'h00100513);
        tick();
`endif

        // Random stalls, redirects, ack timing and occasional resets.
        do_reset(2);
        rand_ack = 1;
        n_consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            br_taken = ($urandom_range(0, 49) == 0);
            br_target = $urandom_range(0, 1023);
            reset = ($urandom_range(0, 499) == 0);
            settle();
            tick();
        end
        reset = 1'b0;
        br_taken = 1'b0;
        stall = 1'b0;
        check("rand_liveness", {31'b0, n_consumed >= 50}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
